// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------------+
// | riscv_pkg : RV32I opcode constants, ALU class / immediate-type enums and  |
// |             small decode helpers shared by the ID/EX stage.               |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  typedef enum logic [1:0] {
    ALU_ARITH  = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_ADDR   = 2'b10,
    ALU_PASSB  = 2'b11
  } alu_class_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_STORE:          return IMM_S;
      OPC_BRANCH:         return IMM_B;
      OPC_LUI, OPC_AUIPC: return IMM_U;
      OPC_JAL:            return IMM_J;
      default:            return IMM_I;
    endcase
  endfunction

  // Only the arith and branch classes carry funct bits in the low nibble.
  function automatic logic [5:0] alu_cntrl_pack(input alu_class_e cls,
                                                input logic f7b5,
                                                input logic [2:0] funct3);
    if (cls == ALU_ARITH || cls == ALU_BRANCH) return {cls, f7b5, funct3};
    return {cls, 4'b0000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// +--------------------------------------------------------------------------+
// | imm_gen  : combinational RV32I immediate extractor, sign-extends the      |
// |            I/S/B/U/J immediate selected by the opcode.                    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  imm_type_e imm_type;

  assign imm_type = imm_type_of(instr[6:0]);

  // Shift immediates use the plain I form; the shifter consumes only bits [4:0].
  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (imm_type)
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h000};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | id_ex_stage : single-entry ID/EX pipeline register with RV32I operand and |
// |               ALU-control decode. Define ID_EX_FWD_EN to enable EX->ID    |
// |               result forwarding onto the source operands.                 |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  input  logic             ex_fwd_valid,
  input  logic [4:0]       ex_fwd_rd,
  input  logic [WIDTH-1:0] ex_fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [5:0]       alu_cntrl,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd_fld;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd_fld = instr[11:7];

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

`ifdef ID_EX_FWD_EN
  assign rs1_val = (ex_fwd_valid && ex_fwd_rd != 5'd0 && ex_fwd_rd == instr[19:15])
                   ? ex_fwd_data : rs1_data;
  assign rs2_val = (ex_fwd_valid && ex_fwd_rd != 5'd0 && ex_fwd_rd == instr[24:20])
                   ? ex_fwd_data : rs2_data;
`else
  logic fwd_unused;
  assign fwd_unused = ^{ex_fwd_valid, ex_fwd_rd, ex_fwd_data};
  assign rs1_val    = rs1_data;
  assign rs2_val    = rs2_data;
`endif

  alu_class_e       dec_cls;
  logic             dec_f7b5;
  logic             dec_we;
  logic             dec_ill;
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic [5:0]       dec_cntrl;

  always_comb begin
    dec_cls  = ALU_ARITH;
    dec_f7b5 = 1'b0;
    dec_we   = 1'b0;
    dec_ill  = 1'b0;
    dec_a    = rs1_val;
    dec_b    = imm;
    case (opcode)
      OPC_OP:     begin dec_f7b5 = instr[30]; dec_b = rs2_val; dec_we = 1'b1; end
      OPC_OPIMM:  begin dec_f7b5 = (funct3 == 3'b101) && instr[30]; dec_we = 1'b1; end
      OPC_BRANCH: begin dec_cls = ALU_BRANCH; dec_b = rs2_val; end
      OPC_LOAD:   begin dec_cls = ALU_ADDR; dec_we = 1'b1; end
      OPC_STORE:  dec_cls = ALU_ADDR;
      OPC_AUIPC,
      OPC_JAL:    begin dec_cls = ALU_ADDR; dec_a = pc; dec_we = 1'b1; end
      OPC_JALR:   begin dec_cls = ALU_ADDR; dec_we = 1'b1; end
      OPC_LUI:    begin dec_cls = ALU_PASSB; dec_a = '0; dec_we = 1'b1; end
      default:    dec_ill = 1'b1;
    endcase
    dec_cntrl = dec_ill ? 6'd0 : alu_cntrl_pack(dec_cls, dec_f7b5, funct3);
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] src_a_q, src_a_d;
  logic [WIDTH-1:0] src_b_q, src_b_d;
  logic [5:0]       alu_cntrl_q, alu_cntrl_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             rd_we_q, rd_we_d;
  logic             illegal_q, illegal_d;
  logic             load;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Flush wins over both a new capture and a drain.
  always_comb begin
    out_valid_d = out_valid_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    alu_cntrl_d = alu_cntrl_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      src_a_d     = dec_a;
      src_b_d     = dec_b;
      alu_cntrl_d = dec_cntrl;
      rd_addr_d   = rd_fld;
      rd_we_d     = dec_we && (rd_fld != 5'd0);
      illegal_d   = dec_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      alu_cntrl_q <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      alu_cntrl_q <= alu_cntrl_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign SrcA      = src_a_q;
  assign SrcB      = src_b_q;
  assign alu_cntrl = alu_cntrl_q;
  assign rd_addr   = rd_addr_q;
  assign rd_we     = rd_we_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage : directed literal checks plus randomized traffic checked  |
// |                  every cycle against a behavioural ID/EX model.           |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        ex_fwd_valid = 1'b0;
  logic [4:0]  ex_fwd_rd = '0;
  logic [31:0] ex_fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [5:0]  alu_cntrl;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .pc           (pc),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_fwd_rd    (ex_fwd_rd),
    .ex_fwd_data  (ex_fwd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .alu_cntrl    (alu_cntrl),
    .rd_addr      (rd_addr),
    .rd_we        (rd_we),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        ill;
    logic        we;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic fv, input logic [4:0] frd,
                                      input logic [31:0] fd);
    exp_t e;
    logic [31:0] v1, v2, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [1:0]  cls;
    logic        f7;
    logic        writes;
    v1 = (FWD && fv && frd != 0 && frd == ins[19:15]) ? fd : r1;
    v2 = (FWD && fv && frd != 0 && frd == ins[24:20]) ? fd : r2;
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_u = {ins[31:12], 12'h000};
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e = '0;
    e.rd = ins[11:7];
    e.a = v1;
    f7 = 1'b0;
    cls = 2'd0;
    writes = 1'b0;
    case (ins[6:0])
      7'h33: begin cls = 0; f7 = ins[30]; e.b = v2; writes = 1; end
      7'h13: begin cls = 0; f7 = (ins[14:12] == 3'd5) ? ins[30] : 1'b0; e.b = imm_i; writes = 1; end
      7'h63: begin cls = 1; e.b = v2; end
      7'h03: begin cls = 2; e.b = imm_i; writes = 1; end
      7'h23: begin cls = 2; e.b = imm_s; end
      7'h17: begin cls = 2; e.a = p; e.b = imm_u; writes = 1; end
      7'h6F: begin cls = 2; e.a = p; e.b = imm_j; writes = 1; end
      7'h67: begin cls = 2; e.b = imm_i; writes = 1; end
      7'h37: begin cls = 3; e.a = 0; e.b = imm_u; writes = 1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e.ctl = 6'd0;
    else if (cls < 2) e.ctl = {cls, f7, ins[14:12]};
    else e.ctl = {cls, 4'd0};
    e.we = writes && !e.ill && (e.rd != 0);
    if (imm_b == 32'hFFFF_FFFF) e.b = imm_b;
    return e;
  endfunction

  logic m_valid = 1'b0;
  exp_t m_e = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_e     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_e     <= ref_decode(instr, pc, rs1_data, rs2_data, ex_fwd_valid, ex_fwd_rd, ex_fwd_data);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  bit cmp_on = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_on && rst_n) begin
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        if (m_valid) begin
          chk("m_illegal", {31'd0, illegal}, {31'd0, m_e.ill});
          chk("m_rd_we", {31'd0, rd_we}, {31'd0, m_e.we});
          chk("m_rd_addr", {27'd0, rd_addr}, {27'd0, m_e.rd});
          chk("m_alu_cntrl", {26'd0, alu_cntrl}, {26'd0, m_e.ctl});
          if (!m_e.ill) begin
            chk("m_SrcA", SrcA, m_e.a);
            chk("m_SrcB", SrcB, m_e.b);
          end
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    instr     = ins;
    rs1_data  = r1;
    rs2_data  = r2;
    out_ready = ordy;
    flush     = fl;
    pc        = 32'h0000_1000;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [6:0] opc_tab [0:10];

  initial begin
    opc_tab = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h17, 7'h6F, 7'h67, 7'h37, 7'h7F, 7'h0B};

    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_SrcA", SrcA, 32'd0);
    chk("rst_SrcB", SrcB, 32'd0);
    chk("rst_alu_cntrl", {26'd0, alu_cntrl}, 32'd0);
    chk("rst_rd", {26'd0, rd_we, rd_addr}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    drive(1, 32'h002081B3, 32'd5, 32'd7, 1, 0);
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_SrcA", SrcA, 32'd5);
    chk("add_SrcB", SrcB, 32'd7);
    chk("add_cntrl", {26'd0, alu_cntrl}, 32'h00);
    chk("add_rd", {26'd0, rd_we, rd_addr}, {26'd0, 1'b1, 5'd3});

    drive(1, 32'h4040D093, 32'h8000_0000, 32'd0, 1, 0);
    tick();
    chk("srai_SrcA", SrcA, 32'h8000_0000);
    chk("srai_SrcB", SrcB, 32'h0000_0404);
    chk("srai_cntrl", {26'd0, alu_cntrl}, 32'b001101);

    drive(1, 32'h123452B7, 32'd9, 32'd9, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      if (i == 0) drive(1, 32'h002081B3, 32'd1, 32'd2, 0, 0);
      chk("lui_SrcA", SrcA, 32'd0);
      chk("lui_SrcB", SrcB, 32'h1234_5000);
      chk("lui_cntrl", {26'd0, alu_cntrl}, 32'b110000);
      chk("lui_rd", {27'd0, rd_addr}, 32'd5);
    end
    tick();
    chk("lui_stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("lui_stall_SrcB", SrcB, 32'h1234_5000);
    drive(0, 32'h0, 32'd0, 32'd0, 1, 0);
    tick();
    chk("lui_drained", {31'd0, out_valid}, 32'd0);

    drive(1, 32'h00500113, 32'd0, 32'd0, 0, 0);
    tick();
    chk("flush_held", SrcB, 32'd5);
    drive(1, 32'h06300193, 32'd0, 32'd0, 0, 1);
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    drive(0, 32'h0, 32'd0, 32'd0, 1, 0);
    tick();
    chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

    drive(1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0);
    tick();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_we", {31'd0, rd_we}, 32'd0);
    chk("ill_cntrl", {26'd0, alu_cntrl}, 32'd0);

    drive(1, 32'h002081B3, 32'd5, 32'd7, 0, 0);
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_SrcA", SrcA, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("after_rst_valid", {31'd0, out_valid}, 32'd0);

`ifdef ID_EX_FWD_EN
    drive(1, 32'h002081B3, 32'd5, 32'd7, 1, 0);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd1; ex_fwd_data = 32'hAA;
    tick();
    chk("fwd_hit_SrcA", SrcA, 32'hAA);
    drive(1, 32'h002081B3, 32'd5, 32'd7, 1, 0);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'hAA;
    tick();
    chk("fwd_x0_SrcA", SrcA, 32'd5);
`endif

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      instr        = $urandom;
      instr[6:0]   = opc_tab[$urandom_range(0, 10)];
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      pc           = $urandom;
      rs1_data     = $urandom;
      rs2_data     = $urandom;
      ex_fwd_valid = $urandom_range(0, 1) == 1;
      ex_fwd_rd    = ($urandom_range(0, 1) == 1) ? instr[19:15] : 5'($urandom);
      ex_fwd_data  = $urandom;
    end
    drive(0, 32'h0, 32'd0, 32'd0, 1, 0);
    repeat (3) tick();
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
